// File: rtl/vga_prefetch_if.sv
// ---------------------------------------------------------------------------
// vga_prefetch_if
// Read-request bus between vga_prefetch and the ZBT memory arbiter.
//   mem_req    requester -> arbiter  read request
//   mem_addr   requester -> arbiter  word address, stable while mem_req && !mem_ack
//   mem_ack    arbiter -> requester  request accepted this cycle
//   mem_rdata  arbiter -> requester  read data, valid a fixed latency after accept
// Modports: master (vga_prefetch side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface vga_prefetch_if #(
   parameter int DATA_W = 36,
   parameter int ADDR_W = 19
) ();
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/vga_prefetch.sv
// ---------------------------------------------------------------------------
// vga_prefetch
// Streams the displayed frame out of ZBT frame memory in raster order as packed
// pixel words (two 18-bit pixels per word) and keeps a small FIFO topped up so
// that every vga_flag pop from vga_write finds a valid word on vga_pixel one
// cycle later.
//
// Ports
//   clock       system clock
//   reset       asynchronous, active-high
//   frame_flag  1-cycle pulse: start of a new frame (flushes and restarts)
//   vga_flag    1-cycle pop request from vga_write
//   vga_pixel   FIFO head word (registered)
//   done_vga    FIFO non-empty, i.e. vga_pixel valid (registered)
//   underflow   sticky: vga_flag arrived while the FIFO was empty
//   mem         vga_prefetch_if.master: mem_req/mem_addr/mem_ack/mem_rdata
//
// Optional feature
//   VGA_PREFETCH_DBLBUF_EN  when defined, every frame_flag toggles the display
//                           buffer; base address is FRAME_OFFSET for buffer 1
//                           and 0 for buffer 0. The first frame after reset
//                           reads buffer 1. When undefined, base is always 0.
// ---------------------------------------------------------------------------
module vga_prefetch #(
   parameter int DATA_W          = 36,
   parameter int ADDR_W          = 19,
   parameter int WORDS_PER_FRAME = 153600,
   parameter int FRAME_OFFSET    = 153600,
   parameter int FIFO_DEPTH      = 8,
   parameter int MEM_LATENCY     = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 frame_flag,
   input  logic                 vga_flag,
   output logic [DATA_W-1:0]    vga_pixel,
   output logic                 done_vga,
   output logic                 underflow,
   vga_prefetch_if.master       mem
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   // Wide enough for queued + in-flight words without wrapping.
   localparam int SUM_W = $clog2(FIFO_DEPTH + MEM_LATENCY + 1);

   localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(WORDS_PER_FRAME);
   localparam logic [ADDR_W-1:0] LAST_WORD   = ADDR_W'(WORDS_PER_FRAME - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0]      word_cnt_q;
   logic [ADDR_W-1:0]      base_addr;
   logic                   mem_req_c;
   logic                   accept;
   logic                   credit_ok;

   logic [MEM_LATENCY-1:0] vld_p;
   logic [SUM_W-1:0]       inflight;

   logic [DATA_W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q, rd_ptr_n;
   logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d, cnt_after_pop;
   logic                   push, pop;
   logic [DATA_W-1:0]      head_d;

   // ------------------------------------------------------------------------
   // Frame base address
   // ------------------------------------------------------------------------
`ifdef VGA_PREFETCH_DBLBUF_EN
   logic disp_buf_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         disp_buf_q <= 1'b0;
      end else if (frame_flag) begin
         disp_buf_q <= ~disp_buf_q;
      end
   end

   assign base_addr = disp_buf_q ? ADDR_W'(FRAME_OFFSET) : '0;
`else
   assign base_addr = '0;
`endif

   // ------------------------------------------------------------------------
   // Request credit: a request may only go out if its data is guaranteed a
   // FIFO slot, counting words queued plus words still in the memory pipe.
   // ------------------------------------------------------------------------
   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
         inflight = inflight + SUM_W'(vld_p[i]);
      end
   end

   assign credit_ok = (SUM_W'(fifo_cnt_q) + inflight) < SUM_W'(FIFO_DEPTH);

   // ------------------------------------------------------------------------
   // Fetch FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_req_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (frame_flag) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (frame_flag) begin
               // Restart: no request in the flush cycle.
               state_d = S_FETCH;
            end else begin
               mem_req_c = credit_ok && (word_cnt_q < FRAME_WORDS);
               if (mem_req_c && mem.mem_ack && (word_cnt_q == LAST_WORD)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (frame_flag) state_d = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign accept       = mem_req_c && mem.mem_ack;
   assign mem.mem_req  = mem_req_c;
   // Counter only moves on accept, so the address is stable while stalled.
   assign mem.mem_addr = base_addr + word_cnt_q;

   // ------------------------------------------------------------------------
   // FIFO push/pop and next head word
   // ------------------------------------------------------------------------
   assign push          = vld_p[MEM_LATENCY-1] && !frame_flag;
   assign pop           = vga_flag && done_vga && !frame_flag;
   assign cnt_after_pop = fifo_cnt_q - CNT_W'(pop);
   assign fifo_cnt_d    = frame_flag ? '0 : (cnt_after_pop + CNT_W'(push));
   assign rd_ptr_n      = rd_ptr_q + PTR_W'(pop);

   // When the pop leaves nothing behind, the incoming word becomes the head
   // directly (it is not in fifo_mem yet). With nothing to show, hold.
   always_comb begin
      head_d = vga_pixel;
      if (push && (cnt_after_pop == '0)) begin
         head_d = mem.mem_rdata;
      end else if (cnt_after_pop != '0) begin
         head_d = fifo_mem[rd_ptr_n];
      end
   end

   // ------------------------------------------------------------------------
   // Control registers, response valid pipe and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         word_cnt_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         vld_p      <= '0;
         done_vga   <= 1'b0;
         vga_pixel  <= '0;
         underflow  <= 1'b0;
      end else begin
         fifo_cnt_q <= fifo_cnt_d;
         done_vga   <= (fifo_cnt_d != '0);
         vga_pixel  <= head_d;
         if (vga_flag && !done_vga) begin
            underflow <= 1'b1;
         end
         if (frame_flag) begin
            // Drop queued words and anything still returning from memory.
            word_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            vld_p      <= '0;
         end else begin
            if (accept) begin
               word_cnt_q <= word_cnt_q + ADDR_W'(1);
            end
            rd_ptr_q <= rd_ptr_n;
            if (push) begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            vld_p[0] <= accept;
            for (int i = 1; i < MEM_LATENCY; i++) begin
               vld_p[i] <= vld_p[i-1];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // FIFO storage (data only, no reset)
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= mem.mem_rdata;
      end
   end

endmodule

// File: tb/tb_vga_prefetch.sv
module tb_vga_prefetch;

   localparam int DATA_W = 36;
   localparam int ADDR_W = 19;
   localparam int WPF    = 64;
   localparam int FOFF   = 1000;
   localparam int DEPTH  = 8;
   localparam int LAT    = 2;
`ifdef VGA_PREFETCH_DBLBUF_EN
   localparam bit DBL = 1'b1;
`else
   localparam bit DBL = 1'b0;
`endif
   // Base of the first frame after reset (buffer 1 when double-buffered).
   localparam int B1 = DBL ? FOFF : 0;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              frame_flag = 1'b0;
   logic              vga_flag = 1'b0;
   logic [DATA_W-1:0] vga_pixel;
   logic              done_vga;
   logic              underflow;

   vga_prefetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

   vga_prefetch #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS_PER_FRAME(WPF),
      .FRAME_OFFSET(FOFF), .FIFO_DEPTH(DEPTH), .MEM_LATENCY(LAT)
   ) dut (
      .clock(clock), .reset(reset), .frame_flag(frame_flag), .vga_flag(vga_flag),
      .vga_pixel(vga_pixel), .done_vga(done_vga), .underflow(underflow), .mem(mif)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int ack_pct = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory responder: returns word = address, LAT cycles after accept.
   typedef struct { int due; logic [ADDR_W-1:0] addr; } resp_t;
   resp_t resp[$];

   // Logs of accepted addresses/cycles and popped words.
   int acc_log[$];
   int acc_cyc[$];
   longint pop_log[$];

   // Behavioural model: frame position, queue of words visible to vga_write,
   // words in flight with their return cycle, sticky underflow.
   typedef struct { int due; logic [DATA_W-1:0] data; } pend_t;
   logic [DATA_W-1:0] m_q[$];
   pend_t m_pend[$];
   int    m_state;   // 0 idle, 1 fetching, 2 frame fully requested
   int    m_widx;
   bit    m_disp;
   bit    m_und;
   bit    exp_req;

   function automatic int mbase();
      return (DBL && m_disp) ? FOFF : 0;
   endfunction

   // Single compare process: checks, logs, then advances the model over the
   // coming clock edge using the inputs that are stable for this cycle.
   always @(negedge clock) begin
      if (reset) begin
         m_q.delete(); m_pend.delete();
         m_state = 0; m_widx = 0; m_disp = 1'b0; m_und = 1'b0;
         resp.delete();
      end else begin
         exp_req = (m_state == 1) && !frame_flag && (m_widx < WPF) &&
                   ((m_q.size() + m_pend.size()) < DEPTH);
         chk("mem_req", mif.mem_req, exp_req);
         if (exp_req) chk("mem_addr", mif.mem_addr, mbase() + m_widx);
         chk("done_vga", done_vga, m_q.size() != 0);
         if (m_q.size() != 0) chk("vga_pixel", vga_pixel, m_q[0]);
         chk("underflow", underflow, m_und);

         if (mif.mem_req && mif.mem_ack) begin
            resp_t r;
            r.due = cyc + LAT; r.addr = mif.mem_addr;
            resp.push_back(r);
            acc_log.push_back(int'(mif.mem_addr));
            acc_cyc.push_back(cyc);
         end
         if (vga_flag && done_vga) pop_log.push_back(longint'(vga_pixel));

         if (vga_flag && m_q.size() == 0) m_und = 1'b1;
         if (frame_flag) begin
            m_q.delete(); m_pend.delete();
            m_widx = 0; m_state = 1;
            if (DBL) m_disp = !m_disp;
         end else begin
            if (vga_flag && m_q.size() != 0) void'(m_q.pop_front());
            while (m_pend.size() > 0 && m_pend[0].due == cyc) begin
               m_q.push_back(m_pend[0].data);
               void'(m_pend.pop_front());
            end
            if (exp_req && mif.mem_ack) begin
               pend_t p;
               p.due = cyc + LAT; p.data = DATA_W'(mbase() + m_widx);
               m_pend.push_back(p);
               m_widx++;
               if (m_widx == WPF) m_state = 2;
            end
         end
      end
   end

   task automatic next_cycle();
      logic [63:0] r;
      @(posedge clock); #1;
      frame_flag = 1'b0;
      vga_flag   = 1'b0;
      mif.mem_ack = ($urandom_range(99) < ack_pct);
      r = {$urandom(), $urandom()};
      mif.mem_rdata = r[DATA_W-1:0];
      while (resp.size() > 0 && resp[0].due <= cyc) begin
         if (resp[0].due == cyc) mif.mem_rdata = DATA_W'(resp[0].addr);
         void'(resp.pop_front());
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done_vga && n < 50) begin next_cycle(); n++; end
      if (n >= 50) begin
         errors++;
         $display("FAIL %s: done_vga never rose within 50 cycles", name);
      end
   endtask

   initial begin
      int rise, n, bad;
      mif.mem_ack = 1'b0;
      mif.mem_rdata = '0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_pixel", vga_pixel, 0);
      chk("rst_done", done_vga, 0);
      chk("rst_req", mif.mem_req, 0);
      chk("rst_addr", mif.mem_addr, 0);
      chk("rst_uf", underflow, 0);
      reset = 1'b0;
      repeat (3) next_cycle();

      // Frame start, ack always high: 8 back-to-back requests then credit stall
      ack_pct = 100;
      next_cycle();
      frame_flag = 1'b1;
      acc_log.delete(); acc_cyc.delete(); pop_log.delete();
      rise = -1;
      for (int i = 0; i < 14; i++) begin
         next_cycle();
         if (done_vga && rise < 0) rise = cyc;
      end
      chk("fill_accepts", acc_log.size(), 8);
      for (int i = 0; i < acc_log.size(); i++) chk("fill_addr", acc_log[i], B1 + i);
      if (acc_cyc.size() >= 8) begin
         chk("fill_consecutive", acc_cyc[7] - acc_cyc[0], 7);
         chk("done_latency", rise - acc_cyc[0], LAT + 1);
      end
      chk("full_no_req", mif.mem_req, 0);

      // 20 pops, one every 4 cycles
      for (int p = 0; p < 20; p++) begin
         next_cycle();
         vga_flag = done_vga;
         repeat (3) next_cycle();
      end
      repeat (4) next_cycle();
      chk("pop_count", pop_log.size(), 20);
      for (int i = 0; i < pop_log.size(); i++) chk("pop_word", pop_log[i], B1 + i);
      chk("no_underflow", underflow, 0);
      chk("refill_accepts", acc_log.size(), 28);

      // Stall: request held with ack low, address must not move
      ack_pct = 0;
      next_cycle();
      vga_flag = 1'b1;
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         chk("stall_req", mif.mem_req, 1);
         chk("stall_addr", mif.mem_addr, B1 + 28);
      end
      chk("stall_no_advance", acc_log.size(), 28);

      // Random ack / pop traffic to the end of the frame
      ack_pct = 60;
      n = 0;
      while (acc_log.size() < WPF && n < 3000) begin
         next_cycle();
         vga_flag = done_vga && ($urandom_range(1) == 1);
         n++;
      end
      if (n >= 3000) begin
         errors++;
         $display("FAIL frame_end: only %0d of %0d accepts", acc_log.size(), WPF);
      end
      chk("frame_accepts", acc_log.size(), WPF);
      if (acc_log.size() > 0) chk("last_addr", acc_log[acc_log.size()-1], B1 + WPF - 1);
      n = 0;
      while (pop_log.size() < WPF && n < 500) begin
         next_cycle();
         vga_flag = done_vga;
         n++;
      end
      next_cycle();
      chk("drained", done_vga, 0);
      chk("done_no_req", mif.mem_req, 0);
      chk("frame_pops", pop_log.size(), WPF);
      bad = 0;
      for (int i = 0; i < pop_log.size(); i++) if (pop_log[i] != longint'(B1 + i)) bad++;
      chk("frame_order", bad, 0);

      // Restart with 2 in flight and 6 queued
      ack_pct = 100;
      next_cycle();
      frame_flag = 1'b1;
      acc_log.delete(); pop_log.delete();
      repeat (9) next_cycle();
      chk("f2_accepts", acc_log.size(), 8);
      if (acc_log.size() > 0) chk("f2_first_addr", acc_log[0], 0);
      chk("f2_busy", done_vga, 1);
      frame_flag = 1'b1;
      next_cycle();
      chk("flush_done", done_vga, 0);
      wait_done("f3_first");
      chk("f3_first_word", vga_pixel, B1);

      // Underflow on empty FIFO, then normal pops
      ack_pct = 0;
      repeat (20) begin next_cycle(); vga_flag = done_vga; end
      next_cycle();
      chk("empty_before_uf", done_vga, 0);
      chk("uf_clear_before", underflow, 0);
      vga_flag = 1'b1;
      next_cycle();
      chk("uf_set", underflow, 1);
      ack_pct = 100;
      repeat (6) next_cycle();
      for (int p = 0; p < 4; p++) begin
         next_cycle();
         vga_flag = done_vga;
         repeat (2) next_cycle();
      end
      chk("uf_sticky", underflow, 1);

      // Async reset mid-fetch with 3 words queued
      next_cycle();
      frame_flag = 1'b1;
      repeat (6) next_cycle();
      chk("pre_reset_busy", done_vga, 1);
      reset = 1'b1;
      #1;
      chk("ar_pixel", vga_pixel, 0);
      chk("ar_done", done_vga, 0);
      chk("ar_req", mif.mem_req, 0);
      chk("ar_addr", mif.mem_addr, 0);
      chk("ar_uf", underflow, 0);
      repeat (2) next_cycle();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         chk("post_reset_idle", mif.mem_req, 0);
      end
      next_cycle();
      frame_flag = 1'b1;
      wait_done("post_reset_first");
      chk("post_reset_word", vga_pixel, B1);
      repeat (3) next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
